if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the single clock and rst is the reset; all registers clear immediately when rst=0, independent of clk.
REQ-002 The block SHALL have port `clk`: input, 1 bit, system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port `rst`: input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port `stall`: input, 6 bits (StallBus). Bit 0 is the IF hold request; Stop=1, NoStop=0.
REQ-005 The block SHALL have port `br_bus`: input, 33 bits, {br_e[32], br_addr[31:0]}. It is the redirect request from the decode stage.
REQ-006 The block SHALL have port `if_to_id_bus`: output, 33 bits, {ce[32], pc[31:0]}. It is the fetch descriptor consumed by decode.
REQ-007 The block SHALL have port `inst_sram_en`: output, 1 bit, instruction SRAM read enable.
REQ-008 The block SHALL have port `inst_sram_wen`: output, 4 bits, instruction SRAM byte write enables.
REQ-009 The block SHALL have port `inst_sram_addr`: output, 32 bits, instruction SRAM address.
REQ-010 The block SHALL have port `inst_sram_wdata`: output, 32 bits, instruction SRAM write data.

Function
REQ-011 The block SHALL hold these state registers: pc_reg[31:0], ce_reg, br_pend, br_tgt_r[31:0].
REQ-012 The block SHALL compute next_pc with this priority:
- br_pend=1: br_tgt_r
- else br_e=1: br_addr
- else: pc_reg+4
REQ-013 The pc_reg+4 sum SHALL be 32-bit modulo arithmetic (0xFFFF_FFFC+4 = 0x0000_0000), with no carry out.
REQ-014 When stall[0]=NoStop on a rising edge, the block SHALL load pc_reg<=next_pc, set ce_reg<=1, and set br_pend<=0.
REQ-015 When stall[0]=Stop on a rising edge, pc_reg and ce_reg SHALL hold their values.
REQ-016 When stall[0]=Stop and br_e=1 on the same edge, the block SHALL set br_pend<=1 and br_tgt_r<=br_addr, so the redirect is not lost.
REQ-017 When repeated br_e pulses arrive while stalled, the latest br_addr SHALL win.
REQ-018 When stall[0]=Stop and br_e=0, br_pend and br_tgt_r SHALL hold.
REQ-019 When stall is released with br_pend=1 and br_e=1 on the same edge, br_tgt_r SHALL take priority per REQ-012; br_addr is ignored.
REQ-020 Branch semantics are MIPS delay slot: the instruction already being fetched when br_e arrives (the slot) is not cancelled, and only the following fetch is redirected. The block SHALL implement no flush.
REQ-021 The block SHALL drive inst_sram_en=ce_reg, inst_sram_addr=pc_reg, inst_sram_wen=4'b0000 and inst_sram_wdata=32'h0. These are combinational from state, with zero latency.
REQ-022 The block SHALL drive if_to_id_bus={ce_reg, pc_reg}, combinationally.
REQ-023 Decode samples if_to_id_bus on the same edge the SRAM read is issued, and read data returns one cycle later, aligned with the registered descriptor.
REQ-024 The block SHALL perform no alignment checking: br_addr[1:0]≠0 is passed through unchanged.
REQ-025 stall[5:1] SHALL be ignored by this block.

Reset
REQ-026 While rst=0, the block SHALL force pc_reg=32'hBFBF_FFFC, ce_reg=0, br_pend=0 and br_tgt_r=0.
REQ-027 During reset the outputs SHALL therefore be inst_sram_en=0, inst_sram_addr=0xBFBF_FFFC and if_to_id_bus={1'b0, 32'hBFBF_FFFC}.
REQ-028 On the first rising edge after rst deasserts, with stall[0]=NoStop, the block SHALL load pc_reg=0xBFC0_0000 and ce_reg=1.
REQ-029 If rst asserts mid-stall with br_pend=1, the pending redirect SHALL be discarded and fetch SHALL restart at 0xBFC0_0000.

Verification
REQ-030 Reset release: rst 0->1, stall=0, br_e=0 -> fetch addresses 0xBFC0_0000, 0xBFC0_0004, 0xBFC0_0008 on consecutive cycles, with inst_sram_en=1 from the first.
REQ-031 Redirect: pc=0xBFC0_0010, br_bus={1, 0xBFC0_0100} for one cycle -> next pc 0xBFC0_0100, then 0xBFC0_0104.
REQ-032 Stall with branch: pc=0xBFC0_0020, stall[0]=1 for 3 cycles, br_e=1 with target 0x8000_0040 in stall cycle 1 only -> pc holds 0xBFC0_0020 for 3 cycles, br_pend=1, then pc=0x8000_0040 on release.
REQ-033 Stall with changing branch: br_e pulses with target 0x100 and then 0x200 during one stall, then release with br_e=1 and target 0x300 -> pc=0x200.
REQ-034 Wrap-around: force pc=0xFFFF_FFFC with no stall -> next pc 0x0000_0000.
REQ-035 Async reset: assert rst mid-cycle while br_pend=1 -> outputs take reset values before the next clock edge, and restart fetch is 0xBFC0_0000.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage (MIPS-style, branch delay slot)
//
// Purpose:
//   Holds the fetch PC and issues one instruction-SRAM read per unstalled
//   cycle. A redirect from decode (br_bus) steers the fetch after the one
//   currently in flight; the in-flight fetch is the delay slot and is never
//   cancelled. A redirect that arrives while the stage is held is parked in
//   a pending register so it survives the stall. When several redirects
//   arrive during one stall, the most recent one is kept.
//
// Ports:
//   clk             in   1   system clock, rising edge
//   rst             in   1   asynchronous reset, active low
//   stall           in   6   stall bus; only bit 0 (IF hold, 1 = stop) used
//   br_bus          in   33  {br_e, br_addr[31:0]} redirect from decode
//   if_to_id_bus    out  33  {ce, pc[31:0]} fetch descriptor to decode
//   inst_sram_en    out  1   instruction SRAM read enable
//   inst_sram_wen   out  4   instruction SRAM byte write enables (always 0)
//   inst_sram_addr  out  32  instruction SRAM address
//   inst_sram_wdata out  32  instruction SRAM write data (always 0)
// ---------------------------------------------------------------------------
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
);

    // The reset PC sits one word below the boot vector so that the first
    // unstalled edge after reset increments it onto 0xBFC0_0000.
    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_br_pend;
    logic [31:0] r_br_tgt;

    logic        w_stop;
    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic [31:0] w_next_pc;
    logic        w_unused_stall;

    assign w_stop    = stall[0];
    assign w_br_e    = br_bus[32];
    assign w_br_addr = br_bus[31:0];

    // Only the IF hold bit matters here; the other stall bits belong to
    // later stages and are deliberately dropped.
    assign w_unused_stall = ^stall[5:1];

    // Next fetch address. A redirect parked during a stall is older than
    // anything on br_bus now, so it wins over a fresh br_e on the release
    // edge. The sequential increment wraps modulo 2^32.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (r_br_pend) begin
            w_next_pc = r_br_tgt;
        end else if (w_br_e) begin
            w_next_pc = w_br_addr;
        end
    end

    // Fetch PC and fetch-valid flag: advance only when the stage is not held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
            r_ce <= 1'b0;
        end else if (!w_stop) begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
        end
    end

    // Pending redirect: consumed by any unstalled edge, captured (latest
    // target wins) by any redirect seen while held, otherwise kept as is.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br_pend <= 1'b0;
            r_br_tgt  <= 32'h0;
        end else if (!w_stop) begin
            r_br_pend <= 1'b0;
        end else if (w_br_e) begin
            r_br_pend <= 1'b1;
            r_br_tgt  <= w_br_addr;
        end
    end

    // SRAM request and decode descriptor come straight from state so that
    // decode registers the descriptor on the same edge the read is issued.
    assign inst_sram_en    = r_ce;
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0;
    assign if_to_id_bus    = {r_ce, r_pc};

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage
//
// A behavioural model of the fetch stream (current fetch address, whether a
// fetch is live, and an optional remembered redirect) is advanced on every
// rising edge and compared with the DUT shortly after each edge. Directed
// sequences pin the model to hand-computed addresses; a randomized phase
// then exercises stalls, redirects, unused stall bits and random resets.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    int checks = 0;
    int errors = 0;

    // Model of the fetch stream.
    logic [31:0] modelPc;
    logic        modelFetching;
    logic        modelHasRedirect;
    logic [31:0] modelRedirect;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_bus         (br_bus),
        .if_to_id_bus   (if_to_id_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model on each rising edge from the inputs present at that
    // edge, then compare the DUT against it 1 ns later.
    always @(posedge clk) begin
        if (!rst) begin
            modelPc          = 32'hBFBF_FFFC;
            modelFetching    = 1'b0;
            modelHasRedirect = 1'b0;
            modelRedirect    = 32'h0;
        end else if (stall[0]) begin
            if (br_bus[32]) begin
                modelHasRedirect = 1'b1;
                modelRedirect    = br_bus[31:0];
            end
        end else begin
            if (modelHasRedirect)
                modelPc = modelRedirect;
            else if (br_bus[32])
                modelPc = br_bus[31:0];
            else
                modelPc = modelPc + 32'd4;
            modelFetching    = 1'b1;
            modelHasRedirect = 1'b0;
        end
        #1;
        checks++;
        if (if_to_id_bus !== {modelFetching, modelPc} ||
            inst_sram_addr !== modelPc || inst_sram_en !== modelFetching ||
            inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL model_compare t=%0t got bus=%h en=%b addr=%h wen=%h wdata=%h expected bus=%h en=%b addr=%h wen=0 wdata=0",
                     $time, if_to_id_bus, inst_sram_en, inst_sram_addr,
                     inst_sram_wen, inst_sram_wdata, {modelFetching, modelPc},
                     modelFetching, modelPc);
        end
    end

    // Drive one cycle of inputs at the falling edge and wait past the
    // following rising edge (and past the model compare).
    task automatic applyStimulus(input logic rstV, input logic stopV,
                                 input logic brE, input logic [31:0] brAddr);
        @(negedge clk);
        rst    = rstV;
        stall  = {5'b0, stopV};
        br_bus = {brE, brAddr};
        @(posedge clk);
        #2;
    endtask

    // Hand-computed literal expectation on the fetch outputs.
    task automatic checkOutput(input string name, input logic expEn,
                               input logic [31:0] expAddr);
        checks++;
        if (inst_sram_en !== expEn || inst_sram_addr !== expAddr ||
            if_to_id_bus !== {expEn, expAddr}) begin
            errors++;
            $display("[TB] FAIL %s got en=%b addr=%h bus=%h expected en=%b addr=%h",
                     name, inst_sram_en, inst_sram_addr, if_to_id_bus,
                     expEn, expAddr);
        end
    endtask

    initial begin
        modelPc          = 32'hBFBF_FFFC;
        modelFetching    = 1'b0;
        modelHasRedirect = 1'b0;
        modelRedirect    = 32'h0;
        rst    = 1'b0;
        stall  = 6'b0;
        br_bus = 33'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_state", 1'b0, 32'hBFBF_FFFC);

        // Reset release: sequential fetch from the boot vector.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("boot_0", 1'b1, 32'hBFC0_0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("boot_4", 1'b1, 32'hBFC0_0004);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("boot_8", 1'b1, 32'hBFC0_0008);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_10", 1'b1, 32'hBFC0_0010);

        // Single-cycle redirect.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hBFC0_0100);
        checkOutput("redirect", 1'b1, 32'hBFC0_0100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("redirect_next", 1'b1, 32'hBFC0_0104);

        // Stall with a branch in the first stall cycle.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hBFC0_0020);
        checkOutput("goto_20", 1'b1, 32'hBFC0_0020);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0040);
        checkOutput("stall_hold_1", 1'b1, 32'hBFC0_0020);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_hold_2", 1'b1, 32'hBFC0_0020);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_hold_3", 1'b1, 32'hBFC0_0020);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("stall_release", 1'b1, 32'h8000_0040);

        // Latest redirect during a stall wins; pending beats br_e on release.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        checkOutput("stall_hold_multi", 1'b1, 32'h8000_0040);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0300);
        checkOutput("pending_priority", 1'b1, 32'h0000_0200);

        // Wrap-around and unaligned pass-through.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("goto_top", 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap", 1'b1, 32'h0000_0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5673);
        checkOutput("unaligned", 1'b1, 32'h1234_5673);

        // Asynchronous reset mid-cycle with a pending redirect.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 32'hBFBF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("reset_held", 1'b0, 32'hBFBF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("restart", 1'b1, 32'hBFC0_0000);

        // Randomized phase, including unused stall bits and rare resets.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            stall        = 6'($urandom);
            stall[0]     = ($urandom_range(0, 99) < 45);
            br_bus[32]   = ($urandom_range(0, 99) < 30);
            br_bus[31:0] = $urandom;
        end
        @(negedge clk);
        rst = 1'b1;
        stall = 6'b0;
        br_bus = 33'b0;
        repeat (2) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
